// File: rtl/parity_restore_if.sv
// Key-restore bus: C||D word in with valid/ready, 64-bit DES key out with valid/ready.
// Bit 0 of each vector is the MSB. The master drives DIN/IN_VALID/OUT_READY.
interface parity_restore_if;
    logic [0:55] DIN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [0:63] DOUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] KEY_CNT;

    modport master (
        output DIN, IN_VALID, OUT_READY,
        input  IN_READY, DOUT, OUT_VALID, KEY_CNT
    );

    modport slave (
        input  DIN, IN_VALID, OUT_READY,
        output IN_READY, DOUT, OUT_VALID, KEY_CNT
    );
endinterface

// File: rtl/parity_restore.sv
// Undo PC-1 on a C||D word and re-insert per-byte parity, giving a standard 64-bit DES key.
// Latency 2 cycles, 1 key/cycle; IN_READY follows OUT_READY combinationally, output holds while stalled.
module parity_restore #(
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    parity_restore_if.slave bus
);

    localparam int PC1 [56] = '{
        56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
    };

    logic [0:63] s1_d, s1_q;
    logic [0:63] s2_d, s2_q;
    logic        v1_q, v2_q;
    logic [15:0] cnt_q;
    logic        adv2;
    logic        xfer_in;

    // PC-1 never touches the parity positions, so they stay 0 in S1.
    for (genvar k = 0; k < 56; k++) begin : g_perm
        assign s1_d[PC1[k]] = bus.DIN[k];
    end

    for (genvar i = 0; i < 8; i++) begin : g_byte
        assign s1_d[8*i+7]     = 1'b0;
        assign s2_d[8*i +: 7]  = s1_q[8*i +: 7];
        assign s2_d[8*i+7]     = ODD_PARITY ? ~^s1_q[8*i +: 7] : ^s1_q[8*i +: 7];
    end

    assign adv2         = v1_q && (!v2_q || bus.OUT_READY);
    assign bus.IN_READY = !v1_q || adv2;
    assign xfer_in      = bus.IN_VALID && bus.IN_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q  <= '0;
            s2_q  <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (xfer_in) begin
                s1_q <= s1_d;
                v1_q <= 1'b1;
            end else if (adv2) begin
                v1_q <= 1'b0;
            end

            if (adv2) begin
                s2_q <= s2_d;
                v2_q <= 1'b1;
            end else if (bus.OUT_READY) begin
                v2_q <= 1'b0;
            end

            if (v2_q && bus.OUT_READY) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.DOUT      = s2_q;
    assign bus.OUT_VALID = v2_q;
    assign bus.KEY_CNT   = cnt_q;

endmodule

// File: tb/tb_parity_restore.sv
// Bench for parity_restore: directed vectors plus a randomized run against a queue-based reference.
// An odd-parity and an even-parity instance run in lockstep on the same stimulus.
module tb_parity_restore;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    parity_restore_if bus_o ();
    parity_restore_if bus_e ();

    assign bus_e.DIN       = bus_o.DIN;
    assign bus_e.IN_VALID  = bus_o.IN_VALID;
    assign bus_e.OUT_READY = bus_o.OUT_READY;

    parity_restore #(.ODD_PARITY(1'b1)) u_dut_odd  (.CLK(CLK), .RST(RST), .bus(bus_o.slave));
    parity_restore #(.ODD_PARITY(1'b0)) u_dut_even (.CLK(CLK), .RST(RST), .bus(bus_e.slave));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    int PC1 [56] = '{
        56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
    };

    // Reference key: key position PC1[j] (MSB = 0) gets input position j, then each byte's LSB is parity.
    function automatic logic [63:0] ref_key(input logic [55:0] d, input bit odd);
        logic [63:0] k;
        logic [6:0]  data;
        k = '0;
        for (int j = 0; j < 56; j++) k[63-PC1[j]] = d[55-j];
        for (int i = 0; i < 8; i++) begin
            data = k[63-8*i -: 7];
            if (odd) k[56-8*i] = ($countones(data) % 2 == 0);
            else     k[56-8*i] = ($countones(data) % 2 == 1);
        end
        return k;
    endfunction

    function automatic logic [55:0] fwd_pc1(input logic [63:0] k);
        logic [55:0] d;
        for (int j = 0; j < 56; j++) d[55-j] = k[63-PC1[j]];
        return d;
    endfunction

    // In-flight keys with the monitor cycle at which each was accepted.
    typedef struct {
        logic [55:0] din;
        int          acc;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   delivered = 0;
    int   accepted = 0;
    bit   exp_vld, exp_rdy;
    int   nbad_o, nbad_e;

    always @(negedge CLK) begin
        if (mon_en) begin
            exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 2);
            exp_rdy = (q.size() < 2) || bus_o.OUT_READY;
            chk("in_ready",  64'(bus_o.IN_READY),  64'(exp_rdy));
            chk("out_valid", 64'(bus_o.OUT_VALID), 64'(exp_vld));
            chk("out_valid_even", 64'(bus_e.OUT_VALID), 64'(exp_vld));
            chk("key_cnt",   64'(bus_o.KEY_CNT),   64'(delivered[15:0]));
            if (exp_vld) begin
                chk("dout_odd",  64'(bus_o.DOUT), ref_key(q[0].din, 1'b1));
                chk("dout_even", 64'(bus_e.DOUT), ref_key(q[0].din, 1'b0));
            end
            if (RST) begin
                q.delete();
                delivered = 0;
            end else begin
                if (exp_vld && bus_o.OUT_READY) begin
                    chk("fwd_pc1", 64'(fwd_pc1(bus_o.DOUT)), 64'(q[0].din));
                    nbad_o = 0;
                    nbad_e = 0;
                    for (int b = 0; b < 8; b++) begin
                        if ($countones(bus_o.DOUT[8*b +: 8]) % 2 == 0) nbad_o++;
                        if ($countones(bus_e.DOUT[8*b +: 8]) % 2 == 1) nbad_e++;
                    end
                    chk("odd_bytes",  64'(nbad_o), 64'd0);
                    chk("even_bytes", 64'(nbad_e), 64'd0);
                    void'(q.pop_front());
                    delivered++;
                end
                if (bus_o.IN_VALID && exp_rdy) begin
                    e.din = bus_o.DIN;
                    e.acc = cyc;
                    q.push_back(e);
                    accepted++;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    logic [55:0] ks [4];
    logic [55:0] ss [3];
    int          nacc;
    int          target;
    int          ncyc;

    initial begin
        RST             = 1'b1;
        bus_o.DIN       = '0;
        bus_o.IN_VALID  = 1'b0;
        bus_o.OUT_READY = 1'b0;
        repeat (3) step();
        RST    = 1'b0;
        mon_en = 1'b1;
        chk("rst_out_valid", 64'(bus_o.OUT_VALID), 64'd0);
        chk("rst_in_ready",  64'(bus_o.IN_READY),  64'd1);
        chk("rst_key_cnt",   64'(bus_o.KEY_CNT),   64'd0);
        chk("rst_dout",      64'(bus_o.DOUT),      64'd0);

        // Standard vector
        bus_o.DIN = 56'hF0CCAAF556678F; bus_o.IN_VALID = 1'b1; bus_o.OUT_READY = 1'b1;
        step();
        bus_o.IN_VALID = 1'b0;
        step();
        chk("std_valid", 64'(bus_o.OUT_VALID), 64'd1);
        chk("std_odd",   64'(bus_o.DOUT), 64'h133457799BBCDFF1);
        chk("std_even",  64'(bus_e.DOUT), 64'h123556789ABDDEF0);
        step();
        chk("std_cnt",   64'(bus_o.KEY_CNT), 64'd1);

        // Corners back to back
        bus_o.DIN = 56'h0; bus_o.IN_VALID = 1'b1;
        step();
        bus_o.DIN = 56'hFFFFFFFFFFFFFF;
        step();
        chk("corner_zero", 64'(bus_o.DOUT), 64'h0101010101010101);
        bus_o.IN_VALID = 1'b0;
        step();
        chk("corner_ones", 64'(bus_o.DOUT), 64'hFEFEFEFEFEFEFEFE);
        step();

        // Streaming: four keys out on consecutive cycles
        for (int i = 0; i < 4; i++) ks[i] = rnd56();
        for (int i = 0; i < 4; i++) begin
            bus_o.DIN = ks[i]; bus_o.IN_VALID = 1'b1;
            step();
            if (i >= 1) begin
                chk("stream_valid", 64'(bus_o.OUT_VALID), 64'd1);
                chk("stream_dout",  64'(bus_o.DOUT), ref_key(ks[i-1], 1'b1));
            end
        end
        bus_o.IN_VALID = 1'b0;
        step();
        chk("stream_last", 64'(bus_o.DOUT), ref_key(ks[3], 1'b1));
        step();

        // Stall: only two keys fit, output held
        for (int i = 0; i < 3; i++) ss[i] = rnd56();
        bus_o.OUT_READY = 1'b0;
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            bus_o.DIN = ss[nacc < 3 ? nacc : 2]; bus_o.IN_VALID = 1'b1;
            #1;
            if (bus_o.IN_READY) nacc++;
            if (c >= 2) chk("stall_dout", 64'(bus_o.DOUT), ref_key(ss[0], 1'b1));
            step();
        end
        chk("stall_accepts", 64'(nacc), 64'd2);
        chk("stall_in_ready", 64'(bus_o.IN_READY), 64'd0);
        chk("stall_valid", 64'(bus_o.OUT_VALID), 64'd1);

        // Release with a simultaneous input transfer
        bus_o.OUT_READY = 1'b1; bus_o.DIN = ss[2]; bus_o.IN_VALID = 1'b1;
        #1;
        chk("release_in_ready", 64'(bus_o.IN_READY), 64'd1);
        step();
        bus_o.IN_VALID = 1'b0;
        chk("release_dout1", 64'(bus_o.DOUT), ref_key(ss[1], 1'b1));
        step();
        chk("release_dout2", 64'(bus_o.DOUT), ref_key(ss[2], 1'b1));
        step();
        chk("release_drained", 64'(bus_o.OUT_VALID), 64'd0);

        // Reset with both stages full
        bus_o.OUT_READY = 1'b0; bus_o.IN_VALID = 1'b1; bus_o.DIN = rnd56();
        step();
        bus_o.DIN = rnd56();
        step();
        #1;
        chk("full_in_ready", 64'(bus_o.IN_READY), 64'd0);
        RST = 1'b1; bus_o.DIN = rnd56();
        step();
        RST = 1'b0; bus_o.IN_VALID = 1'b0; bus_o.OUT_READY = 1'b1;
        #1;
        chk("midrst_valid",    64'(bus_o.OUT_VALID), 64'd0);
        chk("midrst_in_ready", 64'(bus_o.IN_READY),  64'd1);
        chk("midrst_cnt",      64'(bus_o.KEY_CNT),   64'd0);
        repeat (3) begin
            step();
            chk("midrst_no_stale", 64'(bus_o.OUT_VALID), 64'd0);
        end

        // Random traffic
        target = accepted + 10000;
        ncyc   = 0;
        while (accepted < target && ncyc < 40000) begin
            bus_o.DIN       = rnd56();
            bus_o.IN_VALID  = ($urandom_range(0, 9) < 7);
            bus_o.OUT_READY = ($urandom_range(0, 9) < 7);
            step();
            ncyc++;
        end
        chk("rand_budget", 64'(accepted >= target), 64'd1);

        bus_o.IN_VALID = 1'b0; bus_o.OUT_READY = 1'b1;
        repeat (4) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("final_cnt",   64'(bus_o.KEY_CNT), 64'(delivered[15:0]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
